// File: rtl/clk_wiz_pkg.sv
// rtl/clk_wiz_pkg.sv - shared defaults and phase-shift direction type for clk_wiz_0
package clk_wiz_pkg;

  localparam int DIV_DEF         = 8;
  localparam int LOCK_CYCLES_DEF = 64;
  localparam int PS_LATENCY_DEF  = 12;

  typedef enum logic {
    PS_DEC = 1'b0,
    PS_INC = 1'b1
  } ps_dir_e;

endpackage

// File: rtl/clk_wiz_0_ps_ctrl.sv
// rtl/clk_wiz_0_ps_ctrl.sv - phase-shift handshake: busy/latency tracking, psdone, phase offset
module clk_wiz_0_ps_ctrl
  import clk_wiz_pkg::*;
#(
  parameter int DIV        = DIV_DEF,
  parameter int PS_LATENCY = PS_LATENCY_DEF
) (
  input  logic                    clk_in1,
  input  logic                    reset,
  input  logic                    psen,
  input  logic                    psincdec,
  output logic                    hold,
  output logic                    skip,
  output logic                    psdone,
  output logic [$clog2(DIV)-1:0]  ps_phase
);

  localparam int PW  = $clog2(DIV);
  localparam int LTW = $clog2(PS_LATENCY + 1);

  logic           busy;
  logic [LTW-1:0] lat_cnt;
  ps_dir_e        dir;
  logic           apply;

  // lat_cnt is 1 only in the cycle right after acceptance, which is when the divider is steered
  assign apply = busy && (lat_cnt == LTW'(1));
  assign hold  = apply && (dir == PS_INC);
  assign skip  = apply && (dir == PS_DEC);

  always_ff @(posedge clk_in1 or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      lat_cnt  <= '0;
      dir      <= PS_DEC;
      psdone   <= 1'b0;
      ps_phase <= '0;
    end else begin
      psdone <= 1'b0;
      if (!busy) begin
        if (psen) begin
          busy    <= 1'b1;
          lat_cnt <= LTW'(1);
          dir     <= ps_dir_e'(psincdec);
        end
      end else if (lat_cnt == LTW'(PS_LATENCY)) begin
        busy   <= 1'b0;
        psdone <= 1'b1;
      end else begin
        lat_cnt <= lat_cnt + LTW'(1);
      end

      if (hold) begin
        ps_phase <= (ps_phase == PW'(DIV - 1)) ? '0 : ps_phase + PW'(1);
      end else if (skip) begin
        ps_phase <= (ps_phase == '0) ? PW'(DIV - 1) : ps_phase - PW'(1);
      end
    end
  end

endmodule

// File: rtl/clk_wiz_0.sv
// rtl/clk_wiz_0.sv - integer clock divider with lock indicator and dynamic phase shift
module clk_wiz_0
  import clk_wiz_pkg::*;
#(
  parameter int DIV         = DIV_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter int PS_LATENCY  = PS_LATENCY_DEF
) (
  input  logic                    clk_in1,
  input  logic                    reset,
  output logic                    clk_out1,
  input  logic                    psen,
  input  logic                    psincdec,
  output logic                    psdone,
  output logic                    locked,
  output logic [$clog2(DIV)-1:0]  ps_phase
);

  localparam int CW = $clog2(DIV);
  localparam int LW = $clog2(LOCK_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [CW:0]   cnt_sum;
  logic [CW:0]   cnt_step;
  logic [LW-1:0] lock_cnt;
  logic          clk_div;
  logic          hold;
  logic          skip;

  // hold repeats the current count (output later), skip jumps two (output earlier)
  always_comb begin
    cnt_step = hold ? (CW+1)'(0) : (skip ? (CW+1)'(2) : (CW+1)'(1));
    cnt_sum  = {1'b0, cnt} + cnt_step;
    cnt_next = (cnt_sum >= (CW+1)'(DIV)) ? CW'(cnt_sum - (CW+1)'(DIV)) : CW'(cnt_sum);
  end

  assign clk_div = (cnt < CW'(DIV / 2));

  always_ff @(posedge clk_in1 or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      clk_out1 <= 1'b0;
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      clk_out1 <= clk_div & locked;
      if (!locked) begin
        lock_cnt <= lock_cnt + LW'(1);
        locked   <= (lock_cnt == LW'(LOCK_CYCLES - 1));
      end
    end
  end

  clk_wiz_0_ps_ctrl #(
    .DIV        (DIV),
    .PS_LATENCY (PS_LATENCY)
  ) u_ps_ctrl (
    .clk_in1  (clk_in1),
    .reset    (reset),
    .psen     (psen),
    .psincdec (psincdec),
    .hold     (hold),
    .skip     (skip),
    .psdone   (psdone),
    .ps_phase (ps_phase)
  );

endmodule

// File: tb/tb_clk_wiz_0.sv
// tb/tb_clk_wiz_0.sv - directed self-checking bench for clk_wiz_0
module tb_clk_wiz_0;

  logic       clk_in1 = 1'b0;
  logic       reset = 1'b0;
  logic       psen = 1'b0;
  logic       psincdec = 1'b0;
  logic       clk_out1;
  logic       psdone;
  logic       locked;
  logic [2:0] ps_phase;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk_in1 = ~clk_in1;

  clk_wiz_0 #(
    .DIV         (8),
    .LOCK_CYCLES (64),
    .PS_LATENCY  (12)
  ) dut (
    .clk_in1  (clk_in1),
    .reset    (reset),
    .clk_out1 (clk_out1),
    .psen     (psen),
    .psincdec (psincdec),
    .psdone   (psdone),
    .locked   (locked),
    .ps_phase (ps_phase)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in1);
    @(negedge clk_in1);
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // clk_out1 after edge n reflects count after edge n-1, where count(n) = (n - off) mod 8
  task automatic clk_win(input string tag, input int n, input int off);
    int bad;
    logic exp;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      step();
      exp = (((cyc - 1 - off + 64) % 8) < 4);
      if (clk_out1 !== exp) bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    int hi;
    int pulses;
    logic lk63;

    steps(3);
    chk("rst_locked", locked, 0);
    chk("rst_clk_out1", clk_out1, 0);
    chk("rst_psdone", psdone, 0);
    chk("rst_ps_phase", ps_phase, 0);

    // decrement held for two cycles straight out of reset
    reset = 1'b1;
    cyc = 0;
    psen = 1'b1;
    psincdec = 1'b0;
    step();
    chk("dec_accept_phase", ps_phase, 0);
    step();
    psen = 1'b0;
    chk("dec_phase", ps_phase, 7);
    steps(10);
    chk("dec_psdone_early", psdone, 0);
    step();
    chk("dec_psdone", psdone, 1);

    hi = 0;
    pulses = 0;
    lk63 = 1'b1;
    while (cyc < 64) begin
      step();
      hi += int'(clk_out1);
      pulses += int'(psdone);
      if (cyc == 63) lk63 = locked;
    end
    chk("prelock_locked", lk63, 0);
    chk("lock_rise", locked, 1);
    chk("prelock_clk_low", hi, 0);
    chk("dec_no_extra_psdone", pulses, 0);
    chk("dec_phase_held", ps_phase, 7);
    clk_win("clk_after_dec", 16, -1);

    // single increment after lock: 7 wraps to 0
    psen = 1'b1;
    psincdec = 1'b1;
    step();
    psen = 1'b0;
    chk("inc_accept_phase", ps_phase, 7);
    step();
    chk("inc_wrap_phase", ps_phase, 0);
    clk_win("clk_after_inc", 10, 0);
    chk("inc_psdone_early", psdone, 0);
    step();
    chk("inc_psdone", psdone, 1);

    // eight back-to-back increments, each issued in the psdone cycle
    for (int k = 0; k < 8; k++) begin
      psen = 1'b1;
      psincdec = 1'b1;
      step();
      psen = 1'b0;
      chk("burst_psdone_width", psdone, 0);
      step();
      chk("burst_phase", ps_phase, (k + 1) % 8);
      steps(10);
      chk("burst_psdone_early", psdone, 0);
      step();
      chk("burst_psdone", psdone, 1);
    end
    clk_win("clk_realigned", 16, 0);

    // reset five cycles into a request
    psen = 1'b1;
    psincdec = 1'b1;
    step();
    psen = 1'b0;
    step();
    chk("abort_phase_pre", ps_phase, 1);
    steps(3);
    #2 reset = 1'b0;
    #1;
    chk("abort_locked", locked, 0);
    chk("abort_phase", ps_phase, 0);
    chk("abort_clk_out1", clk_out1, 0);
    chk("abort_psdone", psdone, 0);
    pulses = 0;
    repeat (15) begin
      @(negedge clk_in1);
      pulses += int'(psdone);
    end
    reset = 1'b1;
    cyc = 0;
    while (cyc < 63) begin
      step();
      pulses += int'(psdone);
    end
    chk("abort_no_psdone", pulses, 0);
    chk("relock_early", locked, 0);
    chk("relock_phase", ps_phase, 0);
    step();
    chk("relock_rise", locked, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
